// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM port controller slice.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 256;

  // Controller phase: clearing the RAM or serving requesters.
  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_e;

  // Requester identity, also used as the grant-vector bit index.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Requester-side bus of the RAM port controller: CPU load/store port,
// debug loader port and the shared read-data return.
interface ram_port_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;

  logic [DATA_W-1:0] rdata;

  // Requesters drive the request fields and observe grants and read data.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid,
    input  rdata
  );

  // The controller consumes requests and returns grants and read data.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid,
    output rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The last-grant pointer only moves when both
// inputs compete, so a lone requester never costs the other its turn.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_r;

  // Grant decode: single requester wins outright, a tie goes to the one not granted last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_r == REQ_LDR) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Last-grant pointer: advances on contested grants; starts at LDR so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= REQ_LDR;
    end else if (en && (req == 2'b11)) begin
      last_r <= (last_r == REQ_LDR) ? REQ_CPU : REQ_LDR;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Sole owner of the data RAM port: clears every word after reset or on
// init_start, then shares the port between CPU and loader round-robin.
// Optional feature macro: RAM_CTRL_CONFLICT_CNT_EN adds a saturating
// conflict_cnt output counting contested SERVE cycles.
module ram_port_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  ram_port_ctrl_if.slave    bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_CTRL_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_r;
  state_e            next_state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              run_r;
  logic              init_done_r;
  logic              cpu_rvalid_r;
  logic              ldr_rvalid_r;
  logic              arb_en_s;
  logic [1:0]        gnt_s;
  logic              write_s;
  logic              write_last_s;

  // run_r holds the port quiet while reset is asserted, so no write is
  // issued until the cycle after release.
  assign write_s      = (state_r == INIT) && run_r;
  assign write_last_s = write_s && (cnt_r == LAST_ADDR);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en_s),
    .req   ({bus.ldr_req, bus.cpu_req}),
    .gnt   (gnt_s)
  );

  // Next state and RAM port mux: init writes, granted requester, or idle.
  always_comb begin
    next_state_s = state_r;
    arb_en_s     = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = {ADDR_W{1'b0}};
    ram_wdata    = {DATA_W{1'b0}};
    case (state_r)
      INIT: begin
        if (run_r) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cnt_r;
          ram_wdata = INIT_VAL;
        end else begin
          ram_en    = 1'b0;
        end
        if (write_last_s) begin
          next_state_s = SERVE;
        end else begin
          next_state_s = INIT;
        end
      end
      SERVE: begin
        arb_en_s = 1'b1;
        if (gnt_s[REQ_CPU]) begin
          ram_en    = 1'b1;
          ram_we    = bus.cpu_we;
          ram_addr  = bus.cpu_addr;
          ram_wdata = bus.cpu_wdata;
        end else if (gnt_s[REQ_LDR]) begin
          ram_en    = 1'b1;
          ram_we    = bus.ldr_we;
          ram_addr  = bus.ldr_addr;
          ram_wdata = bus.ldr_wdata;
        end else begin
          ram_en    = 1'b0;
        end
        if (init_start) begin
          next_state_s = INIT;
        end else begin
          next_state_s = SERVE;
        end
      end
      default: begin
        next_state_s = INIT;
      end
    endcase
  end

  // State, init counter and done pulse; the counter is parked at zero outside INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT;
      cnt_r       <= {ADDR_W{1'b0}};
      run_r       <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      run_r       <= 1'b1;
      init_done_r <= write_last_s;
      if (write_last_s || (state_r == SERVE)) begin
        cnt_r <= {ADDR_W{1'b0}};
      end else if (write_s) begin
        cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Read-valid flags: one cycle after a read grant, matching the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_r <= 1'b0;
      ldr_rvalid_r <= 1'b0;
    end else begin
      cpu_rvalid_r <= gnt_s[REQ_CPU] && !bus.cpu_we;
      ldr_rvalid_r <= gnt_s[REQ_LDR] && !bus.ldr_we;
    end
  end

  assign init_busy      = (state_r == INIT);
  assign init_done      = init_done_r;
  assign bus.cpu_gnt    = gnt_s[REQ_CPU];
  assign bus.ldr_gnt    = gnt_s[REQ_LDR];
  assign bus.cpu_rvalid = cpu_rvalid_r;
  assign bus.ldr_rvalid = ldr_rvalid_r;
  assign bus.rdata      = (cpu_rvalid_r || ldr_rvalid_r) ? ram_rdata : {DATA_W{1'b0}};

`ifdef RAM_CTRL_CONFLICT_CNT_EN
  logic [15:0] conflict_r;

  // Contention counter: saturating, cleared on every entry into INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_r <= 16'h0000;
    end else if ((state_r == SERVE) && init_start) begin
      conflict_r <= 16'h0000;
    end else if ((state_r == SERVE) && bus.cpu_req && bus.ldr_req && (conflict_r != 16'hFFFF)) begin
      conflict_r <= conflict_r + 16'h0001;
    end else begin
      conflict_r <= conflict_r;
    end
  end

  assign conflict_cnt = conflict_r;
`endif

endmodule
